div: RTL and testbench
======================

# div

Multi-cycle restoring divider serving the EX stage. EX drives operands plus `start_i` / `annul_i`, and holds the pipeline stalled while `ready_o` is low. The divider returns the remainder in `result_o[63:32]` and the quotient in `result_o[31:0]`. EX forwards these as HI and LO respectively to MEM.

## Interface
Parameters:
- none; operand width is fixed by `RegBus` (32) and result width by `DoubleRegBus` (64).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX until it observes `ready_o`.
- `annul_i`  in  1  abort an in-progress division.
- `result_o`  out  64  {remainder, quotient}; valid only while `ready_o` = 1.
- `ready_o`  out  1  1 = result valid (`DivResReady`).

## Operation
States: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END. All outputs are registered.

- **DIV_FREE**
  - If `start_i` = 1 and `annul_i` = 0:
    - latch `signed_div_i` and both operand sign bits;
    - latch |op1| and |op2| (two's-complement magnitude when signed, raw when unsigned; |0x80000000| = 0x80000000 as unsigned);
    - clear the partial remainder `R` (33b) and the counter (6b);
    - if op2 = 0 and `DIV_ZERO_SHORTCUT_EN` is defined, go to DIV_BYZERO; otherwise go to DIV_ON.
  - Otherwise stay in DIV_FREE; `ready_o` = 0, `result_o` = 0.
- **DIV_BYZERO**
  - Next edge: `result_o` = 0, `ready_o` = 1, go to DIV_END.
- **DIV_ON**
  - If `annul_i` = 1: go to DIV_FREE, `ready_o` = 0, `result_o` = 0.
  - Otherwise perform one step per cycle:
    - shift {R, Q} left by 1, bringing in the next dividend MSB;
    - compute T = R − |op2| (33b);
    - if T ≥ 0: R = T and Q[0] = 1; else Q[0] = 0;
    - increment the counter.
  - On the 32nd step (same edge), apply sign correction and go to DIV_END:
    - quotient is negated if signed and the operand signs differ;
    - remainder is negated if signed and the dividend is negative.
  - Register `result_o` = {R[31:0], Q} and set `ready_o` = 1.
- **DIV_END**
  - Hold `result_o` and `ready_o` = 1 while `start_i` = 1.
  - When `start_i` = 0: go to DIV_FREE, `ready_o` = 0, `result_o` = 0.
- Arithmetic rules:
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - No overflow flag is produced.
- `annul_i` is ignored in DIV_FREE (it blocks a start) and in DIV_END.

## Timing
- Reset (`rst` = 0, asynchronous): state DIV_FREE, `ready_o` = 0, `result_o` = 0, counter = 0, latched operands = 0. Reset mid-division abandons it immediately.
- Latency for a start accepted at edge N:
  - normal division: `ready_o` rises after edge N+32 (32 steps on edges N+1..N+32);
  - DIV_BYZERO path: `ready_o` rises after edge N+1.
- `ready_o` stays high at least one cycle and until `start_i` falls. It drops on the first edge that samples `start_i` = 0.
- Operand changes after acceptance are ignored. Back-to-back divisions need one DIV_FREE cycle between them.
- `annul_i` sampled high in DIV_ON returns the block to DIV_FREE on that edge; `ready_o` never asserts for that request.

## Configuration
- `DIV_ZERO_SHORTCUT_EN` defined:
  - divisor 0 takes DIV_BYZERO;
  - result is 0; ready after N+1.
- `DIV_ZERO_SHORTCUT_EN` not defined:
  - divisor 0 runs the full 32 steps;
  - the result is the natural algorithm output after sign correction (unsigned x/0 gives quotient 0xFFFFFFFF, remainder x);
  - ready after N+32.

## Test plan
- Unsigned 100/7, `start_i` held → `ready_o` high after edge N+32; `result_o[63:32]` = 0x2, `result_o[31:0]` = 0xE.
- Signed 0xFFFFFFF9 / 0x2 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 0x1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0x0, `ready_o` after N+32.
- Unsigned 5/0:
  - with the macro: `ready_o` after N+1, `result_o` = 0;
  - without the macro: `ready_o` after N+32, quotient 0xFFFFFFFF, remainder 0x5.
- `annul_i` pulsed at edge N+10 → `ready_o` stays 0, state DIV_FREE. A following 9/3 request returns quotient 0x3, remainder 0x0 after its own N'+32.
- `rst` = 0 asserted mid-division (edge N+15) → outputs 0 immediately. Separately: `start_i` held 5 cycles in DIV_END → `result_o` stable and `ready_o` high for 5 cycles, falling one edge after `start_i` drops.

Source files
------------

// File: rtl/div.sv
// Multi-cycle restoring divider: 32 one-bit steps per request, result held until start drops.
// Optional macro DIV_ZERO_SHORTCUT_EN: zero divisor returns 0 after one cycle instead of 32 steps.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} state_t;

  state_t      state, state_nxt;
  logic        sgn, sgn_nxt;
  logic        neg1, neg1_nxt;
  logic        neg2, neg2_nxt;
  logic [31:0] quo, quo_nxt;
  logic [31:0] dvs, dvs_nxt;
  logic [32:0] rem, rem_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;

  logic [31:0] mag1, mag2;
  logic [33:0] r_sh, t;
  logic [32:0] rem_step;
  logic [31:0] quo_step, q_fix, r_fix;

  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in
  assign r_sh     = {rem, quo[31]};
  assign t        = r_sh - {2'b00, dvs};
  assign rem_step = t[33] ? r_sh[32:0] : t[32:0];
  assign quo_step = {quo[30:0], ~t[33]};
  assign q_fix    = (sgn && (neg1 != neg2)) ? (~quo_step + 32'd1) : quo_step;
  assign r_fix    = (sgn && neg1) ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sgn_nxt    = sgn;
    neg1_nxt   = neg1;
    neg2_nxt   = neg2;
    quo_nxt    = quo;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    cnt_nxt    = cnt;
    result_nxt = result_o;
    ready_nxt  = ready_o;
    case (state)
      DIV_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = 64'd0;
        if (start_i && !annul_i) begin
          sgn_nxt  = signed_div_i;
          neg1_nxt = signed_div_i & opdata1_i[31];
          neg2_nxt = signed_div_i & opdata2_i[31];
          quo_nxt  = mag1;
          dvs_nxt  = mag2;
          rem_nxt  = 33'd0;
          cnt_nxt  = 6'd0;
`ifdef DIV_ZERO_SHORTCUT_EN
          state_nxt = (opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
`else
          state_nxt = DIV_ON;
`endif
        end
      end
      DIV_BYZERO: begin
        result_nxt = 64'd0;
        ready_nxt  = 1'b1;
        state_nxt  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          ready_nxt  = 1'b0;
          result_nxt = 64'd0;
          state_nxt  = DIV_FREE;
        end else begin
          rem_nxt = rem_step;
          quo_nxt = quo_step;
          cnt_nxt = cnt + 6'd1;
          if (cnt == 6'd31) begin
            result_nxt = {r_fix, q_fix};
            ready_nxt  = 1'b1;
            state_nxt  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (!start_i) begin
          ready_nxt  = 1'b0;
          result_nxt = 64'd0;
          state_nxt  = DIV_FREE;
        end
      end
      default: begin
        ready_nxt  = 1'b0;
        result_nxt = 64'd0;
        state_nxt  = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 33'd0;
      cnt      <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      sgn      <= sgn_nxt;
      neg1     <= neg1_nxt;
      neg2     <= neg2_nxt;
      quo      <= quo_nxt;
      dvs      <= dvs_nxt;
      rem      <= rem_nxt;
      cnt      <= cnt_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: arithmetic model plus per-cycle compare of ready_o/result_o.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          checks = 0;
  int          fails  = 0;
  logic        chk_en = 1'b0;
  logic        exp_ready = 1'b0;
  logic [63:0] exp_result = 64'd0;
  logic [63:0] got;

  always #5 clk = ~clk;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  // Plain integer arithmetic: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    la = s ? {{32{a[31]}}, a} : {32'd0, a};
    lb = s ? {{32{b[31]}}, b} : {32'd0, b};
    if (lb == 0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
      q = 0;
      r = 0;
`else
      q = (la < 0) ? -longint'(32'hFFFFFFFF) : longint'(32'hFFFFFFFF);
      r = la;
`endif
    end else begin
      q = la / lb;
      r = la % lb;
    end
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ready_o !== exp_ready || result_o !== exp_result) begin
        fails++;
        $display("FAIL cycle_compare t=%0t got ready=%b result=%h, required ready=%b result=%h",
                 $time, ready_o, result_o, exp_ready, exp_result);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, req);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input int annul_at, output logic [63:0] res);
    logic [63:0] m;
    int lat;
    m = model(s, a, b);
`ifdef DIV_ZERO_SHORTCUT_EN
    lat = (b == 32'd0) ? 1 : 32;
`else
    lat = 32;
`endif
    res = 64'd0;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    annul_i = 1'b0;
    @(posedge clk); #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = ~s;
    for (int k = 1; k <= lat; k++) begin
      if (k == annul_at) annul_i = 1'b1;
      @(posedge clk); #1;
      if (k == annul_at) begin
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      if (k == lat) begin
        exp_ready = 1'b1;
        exp_result = m;
        res = result_o;
      end
    end
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    exp_result = 64'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {63'd0, ready_o} | result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 32'd100, 32'd7, 1, 0, got);
    check("udiv_100_7", got, {32'h2, 32'hE});
    run(1'b1, 32'hFFFFFFF9, 32'h2, 1, 0, got);
    check("sdiv_m7_2", got, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run(1'b1, 32'h7, 32'hFFFFFFFE, 1, 0, got);
    check("sdiv_7_m2", got, {32'h1, 32'hFFFFFFFD});
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 0, got);
    check("sdiv_min_m1", got, {32'h0, 32'h80000000});
    run(1'b0, 32'd5, 32'd0, 1, 0, got);
`ifdef DIV_ZERO_SHORTCUT_EN
    check("udiv_5_0", got, 64'd0);
`else
    check("udiv_5_0", got, {32'h5, 32'hFFFFFFFF});
`endif
    run(1'b0, 32'd123, 32'd45, 1, 10, got);
    check("annul_ready_low", {63'd0, ready_o}, 64'd0);
    run(1'b0, 32'd9, 32'd3, 1, 0, got);
    check("udiv_9_3_after_annul", got, {32'h0, 32'h3});
    run(1'b0, 32'd1000, 32'd10, 5, 0, got);
    check("hold5_1000_10", got, {32'h0, 32'd100});
    run(1'b1, 32'hFFFFFF9C, 32'd7, 1, 0, got);
    run(1'b0, 32'hFFFFFFFF, 32'd1, 2, 0, got);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, 1, 0, got);
    run(1'b1, 32'h12345678, 32'hFFFF0000, 1, 0, got);

    // reset mid-division, after edge N+14
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst_mid_div", {63'd0, ready_o} | result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 32'd77, 32'd5, 1, 0, got);
    check("after_rst_77_5", got, {32'd2, 32'd15});

    // reset while the result is being held
    signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd6; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (32) @(posedge clk);
    #1;
    exp_ready = 1'b1;
    exp_result = {32'd2, 32'd3};
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ready = 1'b0;
    exp_result = 64'd0;
    #1;
    check("rst_in_end", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
